// File: rtl/lut3d_cfg_loader.sv
// 3D LUT reload sequencer: streams exactly GS^3 entries into the LUT
// config port, repairing short or long upstream streams.
module lut3d_cfg_loader #(
  parameter int GS     = 33,
  parameter int LUT_CD = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_start,
  input  logic                i_frame_idle,
  input  logic [LUT_CD*3-1:0] s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [LUT_CD*3-1:0] o_cfg_data,
  output logic                o_cfg_valid,
  output logic                o_cfg_last,
  output logic                o_pix_hold,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_short,
  output logic                o_err_long
);

  localparam int N  = GS * GS * GS;
  localparam int CW = $clog2(N);
  localparam int DW = LUT_CD * 3;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, LOAD, PAD, DRAIN, DONE
  } state_t;

  state_t          st, nxt;
  logic [CW-1:0]   cnt, cnt_n;
  logic            v_n, l_n, es_n, el_n;
  logic [DW-1:0]   d_n;
  logic            at_end;

  assign at_end     = (cnt == LAST);
  assign s_ready    = (st == LOAD) || (st == DRAIN);
  assign o_busy     = (st != IDLE);
  assign o_pix_hold = (st != IDLE);
  assign o_done     = (st == DONE);

  always_comb begin
    nxt   = st;
    cnt_n = cnt;
    v_n   = 1'b0;
    d_n   = '0;
    l_n   = 1'b0;
    es_n  = o_err_short;
    el_n  = o_err_long;
    unique case (st)
      IDLE: begin
        if (i_start) begin
          nxt   = WAIT;
          cnt_n = '0;
          es_n  = 1'b0;
          el_n  = 1'b0;
        end
      end
      WAIT: begin
        if (i_frame_idle) nxt = LOAD;
      end
      LOAD: begin
        if (s_valid) begin
          v_n = 1'b1;
          d_n = s_data;
          l_n = at_end;
          if (at_end) begin
            nxt = s_last ? DONE : DRAIN;
          end else begin
            cnt_n = cnt + CW'(1);
            if (s_last) begin
              nxt  = PAD;
              es_n = 1'b1;
            end
          end
        end
      end
      PAD: begin
        v_n = 1'b1;
        l_n = at_end;
        if (at_end) nxt = DONE;
        else cnt_n = cnt + CW'(1);
      end
      DRAIN: begin
        if (s_valid) begin
          el_n = 1'b1;
          if (s_last) nxt = DONE;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st          <= IDLE;
      cnt         <= '0;
      o_cfg_valid <= 1'b0;
      o_cfg_data  <= '0;
      o_cfg_last  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
    end else begin
      st          <= nxt;
      cnt         <= cnt_n;
      o_cfg_valid <= v_n;
      o_cfg_data  <= d_n;
      o_cfg_last  <= l_n;
      o_err_short <= es_n;
      o_err_long  <= el_n;
    end
  end

endmodule

// File: tb/tb_lut3d_cfg_loader.sv
// Directed bench for lut3d_cfg_loader at GS=5 (125 entries per table).
module tb_lut3d_cfg_loader;

  localparam int GS = 5;
  localparam int CD = 10;
  localparam int N  = GS * GS * GS;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_start, i_frame_idle;
  logic [CD*3-1:0] s_data;
  logic          s_valid, s_last, s_ready;
  logic [CD*3-1:0] o_cfg_data;
  logic          o_cfg_valid, o_cfg_last;
  logic          o_pix_hold, o_busy, o_done;
  logic          o_err_short, o_err_long;

  lut3d_cfg_loader #(.GS(GS), .LUT_CD(CD)) dut (
    .clk(clk), .rstn(rstn),
    .i_start(i_start), .i_frame_idle(i_frame_idle),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready),
    .o_cfg_data(o_cfg_data), .o_cfg_valid(o_cfg_valid),
    .o_cfg_last(o_cfg_last), .o_pix_hold(o_pix_hold),
    .o_busy(o_busy), .o_done(o_done),
    .o_err_short(o_err_short), .o_err_long(o_err_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    nbeats;
    int    last_idx;
    bit    gap;
    int    restart_at;
    bit    exp_short;
    bit    exp_long;
    bit    exp_done_w_last;
  } vec_t;

  vec_t vecs[5];

  int n_chk = 0;
  int n_fail = 0;

  logic [CD*3-1:0] q_data[$];
  bit              q_last[$];
  int              n_done;
  bit              done_w_last;
  bit              done_d = 1'b0;

  task automatic check(string nm, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // Collects every cfg beat and watches the hold release after DONE.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_cfg_valid) begin
        q_data.push_back(o_cfg_data);
        q_last.push_back(o_cfg_last);
      end
      if (o_done) begin
        n_done++;
        if (o_cfg_valid && o_cfg_last) done_w_last = 1'b1;
      end
      if (done_d) check("hold_drop", {o_pix_hold, o_busy}, 0);
      done_d = o_done;
    end else begin
      done_d = 1'b0;
    end
  end

  task automatic check_zero(string nm);
    check(nm, {s_ready, o_cfg_valid, o_cfg_data, o_cfg_last,
               o_pix_hold, o_busy, o_done, o_err_short, o_err_long}, 0);
  endtask

  task automatic start_load(bit fi);
    @(negedge clk);
    q_data.delete();
    q_last.delete();
    n_done = 0;
    done_w_last = 1'b0;
    i_start = 1'b1;
    i_frame_idle = fi;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic feed(int nb, int li, bit gap, int rs, int abort_at);
    int i = 0;
    int guard = 0;
    while (i < nb && guard < 3000) begin
      @(negedge clk);
      guard++;
      i_start = 1'b0;
      if (i == abort_at) return;
      if (s_ready && (!gap || $urandom_range(0, 1) == 1)) begin
        i_start = (i == rs);
        s_valid = 1'b1;
        s_data  = 30'(i);
        s_last  = (i == li);
        i++;
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
    if (guard >= 3000) check("feed_timeout", i, nb);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic finish_check(vec_t v);
    int w = 0;
    int bad = 0;
    int first_bad = -1;
    int nlast = 0;
    int last_pos = -1;
    while (n_done == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check({v.name, "_done_timeout"}, (n_done > 0), 1);
    repeat (3) @(negedge clk);
    check({v.name, "_beats"}, q_data.size(), N);
    foreach (q_data[k]) begin
      longint e;
      e = (k <= v.last_idx && k < v.nbeats) ? k : 0;
      if (q_data[k] !== 30'(e)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (q_last[k]) begin
        nlast++;
        last_pos = k;
      end
    end
    check({v.name, "_data_bad"}, bad, 0);
    check({v.name, "_nlast"}, nlast, 1);
    check({v.name, "_last_pos"}, last_pos, N - 1);
    check({v.name, "_ndone"}, n_done, 1);
    check({v.name, "_err_short"}, o_err_short, v.exp_short);
    check({v.name, "_err_long"}, o_err_long, v.exp_long);
    if (v.exp_done_w_last)
      check({v.name, "_done_w_last"}, done_w_last, 1);
  endtask

  initial begin
    vecs[0] = '{"clean",   125, 124, 0, -1, 0, 0, 1};
    vecs[1] = '{"short",   100,  99, 0, -1, 1, 0, 1};
    vecs[2] = '{"long",    130, 129, 0, -1, 0, 1, 0};
    vecs[3] = '{"gaps",    125, 124, 1, -1, 0, 0, 1};
    vecs[4] = '{"restart", 125, 124, 0, 40, 0, 0, 1};

    rstn = 1'b0;
    i_start = 1'b0;
    i_frame_idle = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rstn = 1'b1;

    for (int t = 0; t < 5; t++) begin
      start_load(1'b1);
      feed(vecs[t].nbeats, vecs[t].last_idx, vecs[t].gap,
           vecs[t].restart_at, -1);
      finish_check(vecs[t]);
    end

    // Frame wait: loader must hold off the stream until the blank.
    begin
      int bad = 0;
      start_load(1'b0);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (s_ready !== 1'b0 || o_pix_hold !== 1'b1) bad++;
      end
      check("wait_hold", bad, 0);
      i_frame_idle = 1'b1;
      @(negedge clk);
      check("wait_ready", s_ready, 1);
      feed(125, 124, 0, -1, -1);
      finish_check(vecs[0]);
    end

    // Reset mid-load, then a clean load.
    start_load(1'b1);
    feed(125, 124, 0, -1, 60);
    check("pre_reset_valid", o_cfg_valid, 1);
    rstn = 1'b0;
    #1;
    check_zero("midload_reset");
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
    rstn = 1'b1;
    start_load(1'b1);
    feed(125, 124, 0, -1, -1);
    finish_check(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lut3d_cfg_loader.md
Name: lut3d_cfg_loader

Overview:
- Sequences reloads of the 3D LUT RAM contents from an upstream valid/ready stream.
- Drives the LUT's cfg_data / cfg_valid / cfg_last interface with exactly GS^3 entries, ordered R fastest, then G, then B.
- Holds the pixel datapath off the shared RAM write port for the whole reload.
- Repairs malformed streams (short: zero-pad; long: discard the excess) so the LUT's internal config counter always ends aligned, and flags the error.

Parameters:
- GS, 33, grid size; GS-1 must be a power of 2 (17, 33, 65).
- LUT_CD, 10, colour depth per channel; entry width is LUT_CD*3.
- N (derived), GS*GS*GS, entries per table.
- CW (derived), $clog2(N), beat counter width.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle request to reload the table; ignored unless in IDLE.
- i_frame_idle  in  1  pixel pipeline idle (vertical blank, no pixels in flight).
- s_data  in  LUT_CD*3  upstream entry {B,G,R}.
- s_valid  in  1  upstream beat valid.
- s_last  in  1  upstream marks its final entry.
- s_ready  out  1  loader accepts the upstream beat.
- o_cfg_data  out  LUT_CD*3  entry to the LUT config port.
- o_cfg_valid  out  1  write strobe to the LUT.
- o_cfg_last  out  1  final entry (index N-1); only ever asserted together with o_cfg_valid.
- o_pix_hold  out  1  pixel source must not issue LUT reads while high.
- o_busy  out  1  reload in progress.
- o_done  out  1  one-cycle pulse when a reload completes.
- o_err_short  out  1  sticky: stream ended early, table was zero-padded.
- o_err_long  out  1  sticky: stream exceeded N entries, excess discarded.

Behaviour:
- Reset values (asynchronous, rstn low):
  - state=IDLE, beat counter=0.
  - All outputs 0, o_cfg_data=0, error flags cleared.
  - Reset mid-load aborts immediately with no further cfg beats. The LUT shares rstn, so its counter also returns to 0.
- States:
  - IDLE: s_ready=0. i_start -> WAIT. On the transition, clear both error flags and the counter.
  - WAIT: o_pix_hold=1, s_ready=0. Leave to LOAD on the first cycle i_frame_idle=1; evaluated in the cycle after WAIT is entered, at the earliest.
  - LOAD: s_ready=1 (the LUT has no backpressure). Each accepted beat (s_valid&&s_ready) increments the counter. Exits:
    - accepted beat at index N-1 with s_last=1 -> DONE.
    - accepted beat at index N-1 with s_last=0 -> DRAIN.
    - accepted beat at index below N-1 with s_last=1 -> PAD, set o_err_short.
  - PAD: s_ready=0. Emit one zero-data cfg beat per cycle, incrementing the counter, until the beat at index N-1 is emitted -> DONE.
  - DRAIN: s_ready=1, accepted beats are discarded (no cfg beat), o_err_long set. Accepted beat with s_last=1 -> DONE.
  - DONE: one cycle; o_done=1 -> IDLE.
- Output timing: o_cfg_valid/o_cfg_data/o_cfg_last are registered, one cycle after acceptance or pad generation. o_cfg_last=1 exactly on the beat whose index is N-1.
- o_pix_hold and o_busy are high whenever state != IDLE, including DONE. This covers the registered final cfg beat, which appears in the DONE cycle. Both drop the cycle after DONE.
- i_frame_idle dropping after LOAD begins is ignored; o_pix_hold is the only interlock.
- s_valid gaps in LOAD: o_cfg_valid=0 for those cycles, counter holds, no timeout.
- i_start while busy: ignored; no queuing.
- Error flags persist until the next accepted i_start.
- Counter arithmetic: unsigned CW bits, compared against N-1. It never wraps because the state changes at N-1.

Test Plan (GS=5, LUT_CD=10, N=125):
- Clean load:
  - Stimulus: i_start, i_frame_idle=1, 125 back-to-back beats with data=index and s_last on beat 124.
  - Required: 125 o_cfg_valid pulses carrying data 0..124; o_cfg_last only with data 124.
  - Required: o_done one cycle later; no error flags; o_pix_hold drops the cycle after o_done.
- Frame wait:
  - Stimulus: i_start with i_frame_idle=0 for 10 cycles, then 1.
  - Required: s_ready=0 and o_pix_hold=1 throughout the wait; the first s_ready=1 appears in the cycle i_frame_idle=1 is sampled in WAIT.
- Short stream:
  - Stimulus: s_last on beat 99.
  - Required: o_err_short=1; 25 zero-data pad beats follow; o_cfg_last on the 125th total beat; o_done pulses.
- Long stream:
  - Stimulus: 130 beats with s_last on beat 129.
  - Required: exactly 125 cfg beats; beats 125..129 are accepted and discarded; o_err_long=1; o_done after beat 129.
- Gaps and reset:
  - Stimulus: random s_valid (50%) during a load.
  - Required: no cfg beats during gaps; ordering and count are preserved.
  - Stimulus: rstn low at beat 60.
  - Required: all outputs 0 immediately; a following clean load succeeds with data 0..124.
- Start while busy:
  - Stimulus: a second i_start pulse at beat 40.
  - Required: no effect; a single o_done at completion.
